// File: rtl/lfsr_pattern_gen_pkg.sv
// Shared types and constants for the LFSR pattern generator family.
// Holds the state encoding, default Galois masks per width and the pass-length clamp.
package lfsr_pattern_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [31:0] TAPS_W32 = 32'h80200003;
    localparam logic [15:0] SEED_W16 = 16'hACE1;

    // Unlisted widths return 0 and must be overridden by the instantiating block.
    function automatic logic [31:0] default_taps(int width);
        case (width)
            8:       return {24'd0, TAPS_W8};
            16:      return {16'd0, TAPS_W16};
            32:      return TAPS_W32;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int clamp_len(int req, int max_len);
        if (req < 1)
            return 1;
        if (req > max_len)
            return max_len;
        return req;
    endfunction

endpackage

// File: rtl/lfsr_pattern_gen_galois_core.sv
// Galois LFSR register with load and advance; any all-zero load is replaced by SEED
// so the register can never lock up.
module lfsr_pattern_gen_galois_core #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             advance,
    output logic [WIDTH-1:0] lfsr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lfsr <= SEED;
        else if (load)
            lfsr <= (load_val == '0) ? SEED : load_val;
        else if (advance)
            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : '0);
    end

endmodule

// File: rtl/lfsr_pattern_gen.sv
// Repeatable symbol source for the game: free-runs for entropy while idle, snapshots a
// round base on start and can rewind to it to regenerate the same symbol sequence.
module lfsr_pattern_gen
    import lfsr_pattern_gen_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(SEED_W16),
    parameter int               SYM_BITS = 2,
    parameter int               MAX_LEN  = 32,
    localparam int              IW       = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_in,
    input  logic                entropy_en,
    input  logic                start,
    input  logic                rewind,
    input  logic [IW-1:0]       seq_len,
    input  logic                step,
    output logic                sym_valid,
    output logic [SYM_BITS-1:0] sym,
    output logic [IW-1:0]       index,
    output logic                done,
    output logic                busy
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] lfsr, base, core_load_val;
    logic [IW-1:0]    len, len_req;
    logic             core_load, core_adv, snap, len_load, idx_clr, fire;

    lfsr_pattern_gen_galois_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (core_load),
        .load_val (core_load_val),
        .advance  (core_adv),
        .lfsr     (lfsr)
    );

    assign len_req = IW'(clamp_len(int'(seq_len), MAX_LEN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Events are strictly prioritised; a lower-priority event in the same cycle is dropped.
    always_comb begin
        state_nxt     = state;
        core_load     = 1'b0;
        core_load_val = seed_in;
        core_adv      = 1'b0;
        snap          = 1'b0;
        len_load      = 1'b0;
        idx_clr       = 1'b0;
        fire          = 1'b0;
        if (seed_load) begin
            core_load = 1'b1;
            idx_clr   = 1'b1;
            state_nxt = IDLE;
        end else if (rewind) begin
            core_load     = 1'b1;
            core_load_val = base;
            len_load      = 1'b1;
            idx_clr       = 1'b1;
            state_nxt     = RUN;
        end else if (start) begin
            snap      = 1'b1;
            len_load  = 1'b1;
            idx_clr   = 1'b1;
            state_nxt = RUN;
        end else if (step && state == RUN) begin
            fire     = 1'b1;
            core_adv = 1'b1;
            if (index + IW'(1) == len)
                state_nxt = DONE;
        end else if (entropy_en && state == IDLE) begin
            core_adv = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base      <= SEED;
            len       <= IW'(1);
            index     <= '0;
            sym_valid <= 1'b0;
            sym       <= '0;
        end else begin
            sym_valid <= fire;
            if (fire)
                sym <= lfsr[SYM_BITS-1:0];
            if (snap)
                base <= (lfsr == '0) ? SEED : lfsr;
            if (len_load)
                len <= len_req;
            if (idx_clr)
                index <= '0;
            else if (fire)
                index <= index + IW'(1);
        end
    end

    assign done = (state == DONE);
    assign busy = (state == RUN);

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Self-checking bench for lfsr_pattern_gen: directed scenarios plus random traffic
// against a behavioural model, and an 8-bit instance for the period check.
module tb_lfsr_pattern_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        seed_load, entropy_en, start, rewind, step;
    logic [15:0] seed_in;
    logic [5:0]  seq_len;
    logic        sym_valid, done, busy;
    logic [1:0]  sym;
    logic [5:0]  index;

    logic        b_entropy;
    logic        b_sym_valid, b_done, b_busy;
    logic [1:0]  b_sym;
    logic [5:0]  b_index;

    int n_checks = 0;
    int n_err    = 0;

    // behavioural model: mode 0 idle, 1 running a pass, 2 pass finished
    logic [15:0] m_lfsr, m_base;
    int          m_len, m_idx, m_mode;
    logic        m_sv;
    logic [1:0]  m_sym;

    always #5 clk = ~clk;

    lfsr_pattern_gen dut (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .entropy_en (entropy_en),
        .start      (start),
        .rewind     (rewind),
        .seq_len    (seq_len),
        .step       (step),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .index      (index),
        .done       (done),
        .busy       (busy)
    );

    lfsr_pattern_gen #(
        .WIDTH (8),
        .TAPS  (8'hB8),
        .SEED  (8'h01)
    ) dut8 (
        .clk        (clk),
        .reset      (reset),
        .seed_load  (1'b0),
        .seed_in    (8'h00),
        .entropy_en (b_entropy),
        .start      (1'b0),
        .rewind     (1'b0),
        .seq_len    (6'd0),
        .step       (1'b0),
        .sym_valid  (b_sym_valid),
        .sym        (b_sym),
        .index      (b_index),
        .done       (b_done),
        .busy       (b_busy)
    );

    function automatic logic [15:0] succ16(logic [15:0] x);
        return (x / 16'd2) ^ ((x % 16'd2 == 16'd1) ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [7:0] succ8(logic [7:0] x);
        return (x / 8'd2) ^ ((x % 8'd2 == 8'd1) ? 8'hB8 : 8'h00);
    endfunction

    function automatic int clampm(int n);
        return (n == 0) ? 1 : ((n > 32) ? 32 : n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr = 16'hACE1; m_base = 16'hACE1; m_len = 1; m_idx = 0;
        m_mode = 0; m_sv = 1'b0; m_sym = 2'd0;
    endtask

    task automatic model_clock();
        m_sv = 1'b0;
        if (seed_load) begin
            m_lfsr = (seed_in == 16'h0) ? 16'hACE1 : seed_in;
            m_mode = 0; m_idx = 0;
        end else if (rewind) begin
            m_lfsr = m_base; m_len = clampm(int'(seq_len)); m_idx = 0; m_mode = 1;
        end else if (start) begin
            m_base = (m_lfsr == 16'h0) ? 16'hACE1 : m_lfsr;
            m_len = clampm(int'(seq_len)); m_idx = 0; m_mode = 1;
        end else if (step && m_mode == 1) begin
            m_sv = 1'b1; m_sym = m_lfsr[1:0]; m_lfsr = succ16(m_lfsr); m_idx++;
            if (m_idx == m_len) m_mode = 2;
        end else if (entropy_en && m_mode == 0) begin
            m_lfsr = succ16(m_lfsr);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_sym_valid"}, 32'(sym_valid), 32'(m_sv));
        chk({tag, "_sym"},       32'(sym),       32'(m_sym));
        chk({tag, "_index"},     32'(index),     32'(m_idx));
        chk({tag, "_done"},      32'(done),      32'(m_mode == 2));
        chk({tag, "_busy"},      32'(busy),      32'(m_mode == 1));
        chk({tag, "_lfsr"},      32'(dut.lfsr),  32'(m_lfsr));
    endtask

    task automatic drive(input string tag, input logic sl, input logic [15:0] si,
                         input logic en, input logic st, input logic rw,
                         input logic [5:0] len, input logic sp);
        @(negedge clk);
        seed_load = sl; seed_in = si; entropy_en = en; start = st;
        rewind = rw; seq_len = len; step = sp;
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        drive(tag, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    endtask

    initial begin
        int          svs;
        int          first_ret;
        logic [7:0]  m8;

        reset = 1'b1; seed_load = 0; seed_in = 0; entropy_en = 0; start = 0;
        rewind = 0; seq_len = 0; step = 0; b_entropy = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all("reset");
        @(negedge clk); reset = 1'b0;

        // 1: ACE1 pass of three symbols
        drive("t1_load",  1, 16'hACE1, 0, 0, 0, 6'd0, 0);
        drive("t1_start", 0, 16'h0,    0, 1, 0, 6'd3, 0);
        drive("t1_s1",    0, 16'h0,    0, 0, 0, 6'd0, 1);
        chk("t1_sym1", 32'(sym), 32'd1); chk("t1_idx1", 32'(index), 32'd1);
        drive("t1_s2",    0, 16'h0,    0, 0, 0, 6'd0, 1);
        chk("t1_sym2", 32'(sym), 32'd0); chk("t1_idx2", 32'(index), 32'd2);
        drive("t1_s3",    0, 16'h0,    0, 0, 0, 6'd0, 1);
        chk("t1_sym3", 32'(sym), 32'd0); chk("t1_idx3", 32'(index), 32'd3);
        chk("t1_done", 32'(done), 32'd1);
        idle("t1_idle");

        // 2: rewind replays the same symbols; step in DONE ignored
        drive("t2_rw", 0, 16'h0, 0, 0, 1, 6'd3, 0);
        drive("t2_s1", 0, 16'h0, 0, 0, 0, 6'd0, 1); chk("t2_sym1", 32'(sym), 32'd1);
        drive("t2_s2", 0, 16'h0, 0, 0, 0, 6'd0, 1); chk("t2_sym2", 32'(sym), 32'd0);
        drive("t2_s3", 0, 16'h0, 0, 0, 0, 6'd0, 1); chk("t2_sym3", 32'(sym), 32'd0);
        drive("t2_xs", 0, 16'h0, 0, 0, 0, 6'd0, 1);
        chk("t2_extra_sv", 32'(sym_valid), 32'd0); chk("t2_extra_idx", 32'(index), 32'd3);

        // 3: zero seed guard, entropy in IDLE only
        drive("t3_load0", 1, 16'h0, 0, 0, 0, 6'd0, 0);
        chk("t3_zero_seed", 32'(dut.lfsr), 32'hACE1);
        for (int i = 0; i < 5; i++) drive("t3_ent", 0, 16'h0, 1, 0, 0, 6'd0, 0);
        chk("t3_ent5", 32'(dut.lfsr), 32'h0E27);
        drive("t3_start", 0, 16'h0, 1, 1, 0, 6'd4, 0);
        drive("t3_run_ent", 0, 16'h0, 1, 0, 0, 6'd0, 0);
        chk("t3_run_noadv", 32'(dut.lfsr), 32'h0E27);

        // 4: simultaneous events
        drive("t4_s1",    0, 16'h0, 0, 0, 0, 6'd0, 1);
        drive("t4_strw",  0, 16'h0, 0, 0, 1, 6'd4, 1);
        chk("t4_strw_sv", 32'(sym_valid), 32'd0); chk("t4_strw_idx", 32'(index), 32'd0);
        chk("t4_strw_lfsr", 32'(dut.lfsr), 32'h0E27);
        drive("t4_slst",  1, 16'h1234, 0, 1, 0, 6'd4, 0);
        chk("t4_slst_busy", 32'(busy), 32'd0);
        drive("t4_rw",    0, 16'h0, 0, 0, 1, 6'd4, 0);
        chk("t4_nosnap", 32'(dut.lfsr), 32'h0E27);

        // 5: async reset mid-pass, rewind after reset, length clamps
        drive("t5_s1", 0, 16'h0, 0, 0, 0, 6'd0, 1);
        @(negedge clk); #2 reset = 1'b1; #1;
        model_reset();
        check_all("t5_async");
        @(negedge clk); reset = 1'b0;
        drive("t5_rw0", 0, 16'h0, 0, 0, 1, 6'd2, 0);
        drive("t5_rw_s", 0, 16'h0, 0, 0, 0, 6'd0, 1);
        chk("t5_rw_sym", 32'(sym), 32'd1);
        drive("t5_len0", 0, 16'h0, 0, 1, 0, 6'd0, 0);
        drive("t5_l0s1", 0, 16'h0, 0, 0, 0, 6'd0, 1);
        drive("t5_l0s2", 0, 16'h0, 0, 0, 0, 6'd0, 1);
        chk("t5_len0_idx", 32'(index), 32'd1); chk("t5_len0_done", 32'(done), 32'd1);
        drive("t5_len40", 0, 16'h0, 0, 1, 0, 6'd40, 0);
        svs = 0;
        for (int i = 0; i < 34; i++) begin
            drive("t5_l40s", 0, 16'h0, 0, 0, 0, 6'd0, 1);
            if (sym_valid) svs++;
        end
        chk("t5_len40_syms", 32'(svs), 32'd32);
        chk("t5_len40_idx", 32'(index), 32'd32);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive("rnd",
                  ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom),
                  1'($urandom),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 15) == 0),
                  6'($urandom_range(0, 40)),
                  1'($urandom));
        end
        idle("rnd_end");

        // 6: 8-bit period
        @(negedge clk);
        chk("t6_init", 32'(dut8.lfsr), 32'h01);
        b_entropy = 1'b1;
        m8 = 8'h01;
        first_ret = 0;
        for (int i = 1; i <= 255; i++) begin
            @(posedge clk); #1;
            m8 = succ8(m8);
            if (dut8.lfsr == 8'h00) chk("t6_zero", 32'(dut8.lfsr), 32'h1);
            if (dut8.lfsr != m8) chk("t6_seq", 32'(dut8.lfsr), 32'(m8));
            if (dut8.lfsr == 8'h01 && first_ret == 0) first_ret = i;
        end
        b_entropy = 1'b0;
        chk("t6_period", 32'(first_ret), 32'd255);
        chk("t6_final", 32'(dut8.lfsr), 32'h01);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
